// File: rtl/link_master_burst.sv
// Four-phase req/ack link master streaming a burst of upstream valid/ready words to a slave,
// with per-phase ack timeout, abort-and-drain recovery and a completed-word count.
module link_master_burst #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic              ack,
  output logic              req,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4,
    S_ERR    = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BURST);
  // The abort fires on the cycle the counter would step to TIMEOUT, so err lands TIMEOUT cycles after phase entry.
  localparam logic [TO_W-1:0]  TO_LIM  = (TIMEOUT == 0) ? {TO_W{1'b0}} : TO_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     phase_q, phase_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                req_q, done_q, err_q, busy_q, src_ready_q;
  logic                to_hit;

  assign to_hit = (TIMEOUT != 0) && (phase_q == TO_LIM);

  // Next-state, burst length, word count, phase counter and data capture.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = {CNT_W{1'b0}};
          if (burst_len == {CNT_W{1'b0}}) begin
            state_d = S_FINISH;
          end else begin
            len_d   = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (src_valid) begin
          data_d  = src_data;
          phase_d = {TO_W{1'b0}};
          state_d = S_REQ;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_REQ: begin
        if (ack) begin
          cnt_d   = cnt_q + CNT_W'(1);
          phase_d = {TO_W{1'b0}};
          state_d = S_WAIT;
        end else if (to_hit) begin
          state_d = S_ERR;
        end else begin
          phase_d = phase_q + TO_W'(1);
        end
      end
      S_WAIT: begin
        if (!ack) begin
          state_d = (cnt_q == len_q) ? S_FINISH : S_LOAD;
        end else if (to_hit) begin
          state_d = S_ERR;
        end else begin
          phase_d = phase_q + TO_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERR:    state_d = S_DRAIN;
      S_DRAIN: begin
        if (!ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; outputs are decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= {CNT_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      phase_q     <= {TO_W{1'b0}};
      data_q      <= {DATA_W{1'b0}};
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      src_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      data_q      <= data_d;
      req_q       <= (state_d == S_REQ);
      done_q      <= (state_d == S_FINISH);
      err_q       <= (state_d == S_ERR);
      busy_q      <= (state_d != S_IDLE);
      src_ready_q <= (state_d == S_LOAD);
    end
  end

  assign req        = req_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign src_ready  = src_ready_q;
  assign data       = data_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_link_master_burst.sv
// Directed bench for link_master_burst: bursts, zero length, stall, timeouts, reset, clamp.
module tb_link_master_burst;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  burst_len;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              ack;
  logic              req;
  logic [DATA_W-1:0] data;
  logic              done;
  logic              err;
  logic              busy;
  logic [CNT_W-1:0]  xfer_count;
  logic [4:0]        o;

  int vec = 0;
  int bad = 0;

  // {req, done, err, busy, src_ready}
  assign o = {req, done, err, busy, src_ready};

  link_master_burst #(.DATA_W(8), .MAX_BURST(16), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ack(ack), .req(req), .data(data), .done(done), .err(err),
    .busy(busy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic start_burst(input int len);
    @(negedge clk);
    start = 1'b1;
    burst_len = CNT_W'(len);
    @(negedge clk);
    start = 1'b0;
    vec++;
    if (len == 0) begin
      if (o !== 5'b01010 || xfer_count !== 5'd0) begin
        bad++;
        $display("FAIL start_zero: flags %b cnt %0d, want 01010 cnt 0", o, xfer_count);
      end
    end else begin
      if (o !== 5'b00011 || xfer_count !== 5'd0) begin
        bad++;
        $display("FAIL start_load: flags %b cnt %0d, want 00011 cnt 0", o, xfer_count);
      end
    end
  endtask

  // Entered with the master in LOAD; ends at the cycle after ack falls (LOAD or FINISH).
  task automatic xfer_word(input logic [7:0] w, input int stall, input int idx, input int n);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      vec++;
      if (o !== 5'b00011) begin
        bad++;
        $display("FAIL stall: flags %b, want 00011 (cycle %0d)", o, i);
      end
    end
    src_valid = 1'b1;
    src_data  = w;
    @(negedge clk);
    src_valid = 1'b0;
    src_data  = ~w;
    vec++;
    if (o !== 5'b10010 || data !== w) begin
      bad++;
      $display("FAIL req_rise: flags %b data %h, want 10010 data %h", o, data, w);
    end
    @(negedge clk);
    vec++;
    if (o !== 5'b10010 || data !== w) begin
      bad++;
      $display("FAIL req_hold: flags %b data %h, want 10010 data %h", o, data, w);
    end
    ack = 1'b1;
    @(negedge clk);
    vec++;
    if (o !== 5'b00010 || xfer_count !== CNT_W'(idx + 1)) begin
      bad++;
      $display("FAIL wait: flags %b cnt %0d, want 00010 cnt %0d", o, xfer_count, idx + 1);
    end
    ack = 1'b0;
    @(negedge clk);
    vec++;
    if (idx + 1 == n) begin
      if (o !== 5'b01010 || xfer_count !== CNT_W'(n) || data !== w) begin
        bad++;
        $display("FAIL finish: flags %b cnt %0d data %h, want 01010 cnt %0d data %h",
                 o, xfer_count, data, n, w);
      end
    end else begin
      if (o !== 5'b00011 || data !== w) begin
        bad++;
        $display("FAIL next_load: flags %b data %h, want 00011 data %h", o, data, w);
      end
    end
  endtask

  task automatic finish_idle(input int n, input logic [7:0] last);
    @(negedge clk);
    vec++;
    if (o !== 5'b00000 || xfer_count !== CNT_W'(n) || data !== last) begin
      bad++;
      $display("FAIL idle: flags %b cnt %0d data %h, want 00000 cnt %0d data %h",
               o, xfer_count, data, n, last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (o !== 5'b00000 || data !== 8'h00 || xfer_count !== 5'd0) begin
      bad++;
      $display("FAIL reset: flags %b data %h cnt %0d, want all zero", o, data, xfer_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_burst4();
    start_burst(4);
    xfer_word(8'hA0, 0, 0, 4);
    xfer_word(8'hA1, 0, 1, 4);
    xfer_word(8'hA2, 0, 2, 4);
    xfer_word(8'hA3, 0, 3, 4);
    finish_idle(4, 8'hA3);
  endtask

  task automatic test_zero_len();
    start_burst(0);
    finish_idle(0, 8'hA3);
  endtask

  task automatic test_stall();
    start_burst(3);
    xfer_word(8'hB0, 0, 0, 3);
    xfer_word(8'hB1, 5, 1, 3);
    xfer_word(8'hB2, 0, 2, 3);
    finish_idle(3, 8'hB2);
  endtask

  task automatic test_timeout_no_ack();
    start_burst(4);
    xfer_word(8'hD0, 0, 0, 4);
    xfer_word(8'hD1, 0, 1, 4);
    src_valid = 1'b1;
    src_data  = 8'hD2;
    @(negedge clk);
    src_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (o !== 5'b10010) begin
        bad++;
        $display("FAIL to_req_wait: flags %b, want 10010 (cycle %0d)", o, i);
      end
      @(negedge clk);
    end
    vec++;
    if (o !== 5'b00110 || xfer_count !== 5'd2) begin
      bad++;
      $display("FAIL to_err_req: flags %b cnt %0d, want 00110 cnt 2", o, xfer_count);
    end
    @(negedge clk);
    vec++;
    if (o !== 5'b00010) begin
      bad++;
      $display("FAIL to_drain: flags %b, want 00010", o);
    end
    finish_idle(2, 8'hD2);
  endtask

  task automatic test_timeout_ack_high();
    start_burst(4);
    xfer_word(8'hE0, 0, 0, 4);
    xfer_word(8'hE1, 0, 1, 4);
    src_valid = 1'b1;
    src_data  = 8'hE2;
    @(negedge clk);
    src_valid = 1'b0;
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec++;
      if (o !== 5'b00010) begin
        bad++;
        $display("FAIL to_wait_hold: flags %b, want 00010 (cycle %0d)", o, i);
      end
    end
    @(negedge clk);
    vec++;
    if (o !== 5'b00110 || xfer_count !== 5'd3) begin
      bad++;
      $display("FAIL to_err_wait: flags %b cnt %0d, want 00110 cnt 3", o, xfer_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (o !== 5'b00010) begin
        bad++;
        $display("FAIL drain_hold: flags %b, want 00010 (cycle %0d)", o, i);
      end
    end
    ack = 1'b0;
    finish_idle(3, 8'hE2);
  endtask

  task automatic test_reset_mid_burst();
    start_burst(3);
    src_valid = 1'b1;
    src_data  = 8'h5A;
    @(negedge clk);
    src_valid = 1'b0;
    vec++;
    if (req !== 1'b1) begin
      bad++;
      $display("FAIL mid_req: req %b, want 1", req);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (o !== 5'b00000 || data !== 8'h00 || xfer_count !== 5'd0) begin
      bad++;
      $display("FAIL async_reset: flags %b data %h cnt %0d, want all zero", o, data, xfer_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_burst(2);
    xfer_word(8'h61, 0, 0, 2);
    xfer_word(8'h62, 0, 1, 2);
    finish_idle(2, 8'h62);
  endtask

  task automatic test_start_ignored();
    start_burst(2);
    start = 1'b1;
    burst_len = 5'd7;
    xfer_word(8'hC0, 0, 0, 2);
    xfer_word(8'hC1, 0, 1, 2);
    start = 1'b0;
    finish_idle(2, 8'hC1);
  endtask

  task automatic test_clamp();
    start_burst(20);
    for (int i = 0; i < 16; i++) begin
      xfer_word(8'(8'h40 + i), 0, i, 16);
    end
    finish_idle(16, 8'h4F);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    burst_len = 5'd0;
    src_valid = 1'b0;
    src_data = 8'h00;
    ack = 1'b0;
    test_reset();
    test_burst4();
    test_zero_len();
    test_stall();
    test_timeout_no_ack();
    test_timeout_ack_high();
    test_reset_mid_burst();
    test_start_ignored();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/link_master_burst.md
# link_master_burst

Parametrised four-phase req/ack link master that streams a variable-length burst of DATA_W-bit words from an upstream valid/ready source to a slave. It supports configurable burst length per command, upstream back-pressure, per-phase ack timeout with abort, and a completed-word count. It sits between a local data producer and the slave FSM on the point-to-point link, and replaces the fixed 4-byte master.

## Interface
Parameters:
- DATA_W, 8, link data width in bits.
- MAX_BURST, 16, largest burst in words; CNT_W = $clog2(MAX_BURST+1).
- TIMEOUT, 255, cycles allowed per handshake phase before abort; 0 disables the timeout.
- TO_W, 8, timeout counter width; must hold TIMEOUT.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rst_n, input, 1, reset, asynchronous and active-low; deassertion is synchronous to clk.
- start, input, 1, command strobe; sampled only in IDLE.
- burst_len, input, CNT_W, words in the burst; captured when start is accepted.
- src_valid, input, 1, upstream word available.
- src_data, input, DATA_W, upstream word.
- src_ready, output, 1, upstream word accepted this cycle; high only in LOAD.
- ack, input, 1, slave acknowledge; already synchronised to clk by the slave side.
- req, output, 1, link request.
- data, output, DATA_W, link data; stable whenever req=1.
- done, output, 1, one-cycle pulse when the burst completes.
- err, output, 1, one-cycle pulse when a timeout aborts the burst.
- busy, output, 1, high in any state other than IDLE.
- xfer_count, output, CNT_W, words completed in the current or last burst.

## Operation
- States: IDLE, LOAD, REQ, WAIT, FINISH, ERR, DRAIN.
- IDLE:
  - start=1 with burst_len≠0: capture len=min(burst_len, MAX_BURST), clear xfer_count, go to LOAD.
  - start=1 with burst_len=0: go to FINISH.
  - start is ignored in every other state.
- LOAD:
  - src_ready=1.
  - On src_valid=1: register src_data into data, go to REQ.
  - There is no timeout in LOAD.
- REQ:
  - req=1.
  - On ack=1: xfer_count+1, go to WAIT.
- WAIT:
  - req=0.
  - On ack=0: go to FINISH if xfer_count==len, otherwise go to LOAD.
- FINISH: done=1 for one cycle, then go to IDLE.
- Timeout:
  - The phase counter clears on entry to REQ or WAIT and increments each cycle the exit condition is false.
  - When it reaches TIMEOUT (TIMEOUT≠0), go to ERR.
- ERR: err=1 and req=0 for one cycle, then go to DRAIN.
- DRAIN: wait for ack=0, then go to IDLE. There is no timeout in DRAIN.
- xfer_count is not cleared by an abort; it reports the words acknowledged before the abort.
- Output decoding:
  - req, done, err and busy decode from the registered state only; there are no combinational paths from inputs to these outputs.
  - src_ready also decodes from state only.
- data holds its last value outside LOAD→REQ updates.

## Timing
- Reset (rst_n=0, any time, including mid-burst):
  - state=IDLE.
  - req, done, err, busy, src_ready = 0.
  - data=0, xfer_count=0, phase counter=0.
  - req drops immediately, without waiting for clk.
- Latency:
  - start sampled at edge N → LOAD at N+1.
  - src_valid sampled in LOAD at edge M → req=1 and new data from M+1.
  - ack high sampled at edge K → req=0 from K+1.
  - ack low sampled at edge J in WAIT → LOAD (or FINISH) from J+1.
  - The next req rises at J+2 at the earliest.
- Four-phase rule: req never re-rises until ack has been sampled low. data changes only while req=0 and the state is LOAD.
- A zero-length burst gives done at N+1 and never asserts req.
- done and err are never high together. After an abort, neither pulses again until a new start.
- The count saturates at len by construction; burst_len>MAX_BURST is clamped.

## Test plan
- Burst of 4 words with DATA_W=8 and src words A0..A3; slave acks 2 cycles after req and drops ack 1 cycle after req falls.
  - Expect 4 req pulses carrying data A0, A1, A2, A3.
  - Expect done one cycle after the final ack falls, xfer_count=4, and err never asserting.
- burst_len=0 → done at N+1, req stays 0 throughout, xfer_count=0.
- Upstream stall: src_valid held low 5 cycles in LOAD before word 2.
  - Expect src_ready held high and req held low throughout the stall.
  - Expect no timeout and the burst to complete normally.
- Timeouts with TIMEOUT=4:
  - ack never rises on word 3 → err pulse 4 cycles after REQ entry, req=0, xfer_count=2.
  - Same setup with ack held high → DRAIN until ack is released, then IDLE.
- rst_n pulsed low while req=1 mid-burst:
  - req falls asynchronously and all outputs return to their reset values.
  - A new start after reset runs a clean burst.
- start=1 asserted during a burst with burst_len=7 → ignored; the current burst finishes with its original length.
